// File: rtl/spi_rx_mlane_if.sv
// Output word stream of spi_rx_mlane: registered word, valid/ready handshake and last-word marker.
interface spi_rx_mlane_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  last;
  logic                  ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/spi_rx_mlane.sv
// SPI master receive datapath: packs 1/2/4-lane samples into DATA_WIDTH words with a 1-entry output register.
// Optional LSB-first packing is enabled by defining SPI_RX_LSB_FIRST_EN.
module spi_rx_mlane #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 rx_edge_i,
  input  logic [3:0]           sdi_i,
  input  logic [1:0]           mode_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 len_upd_i,
`ifdef SPI_RX_LSB_FIRST_EN
  input  logic                 lsb_first_i,
`endif
  spi_rx_mlane_if.master       rx_out,
  output logic                 done_o,
  output logic                 clk_en_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam int WB_W = $clog2(DATA_WIDTH);
  localparam logic [WB_W-1:0]       WB_ZERO   = WB_W'(0);
  localparam logic [WB_W-1:0]       WB_ONE    = WB_W'(1);
  localparam logic [WB_W-1:0]       WB_LAST_1 = WB_W'(DATA_WIDTH - 1);
  localparam logic [WB_W-1:0]       WB_LAST_2 = WB_W'(DATA_WIDTH / 2 - 1);
  localparam logic [WB_W-1:0]       WB_LAST_4 = WB_W'(DATA_WIDTH / 4 - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  LEN_RST   = CNT_WIDTH'(8);
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

  state_t                state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0]  beat_cnt_r, len_q_r, beats_s;
  logic [WB_W-1:0]       wbeat_r, wb_last_s;
  logic [1:0]            mode_q_r;
  logic [DATA_WIDTH-1:0] shift_r, shift_nxt_s, data_r, load_word_s;
  logic                  valid_r, last_r, done_r, stall_last_r;
  logic                  beat_s, final_s, boundary_s, free_s, load_s, load_last_s;
  logic                  lsb_first_s;

`ifdef SPI_RX_LSB_FIRST_EN
  logic lsb_first_r;
  assign lsb_first_s = lsb_first_r;
`else
  assign lsb_first_s = 1'b0;
`endif

  // One beat of L lanes; sdi1 is the single-lane input, lane order sdi3..sdi0 is kept in both directions.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sh,
                                                     input logic [1:0] mode,
                                                     input logic [3:0] sdi,
                                                     input logic lsb);
    logic [DATA_WIDTH-1:0] res;
    res = sh;
    case (mode)
      2'd1: begin
        if (lsb) res = {sdi[1:0], sh[DATA_WIDTH-1:2]};
        else     res = {sh[DATA_WIDTH-3:0], sdi[1:0]};
      end
      2'd2: begin
        if (lsb) res = {sdi[3:0], sh[DATA_WIDTH-1:4]};
        else     res = {sh[DATA_WIDTH-5:0], sdi[3:0]};
      end
      default: begin
        if (lsb) res = {sdi[1], sh[DATA_WIDTH-1:1]};
        else     res = {sh[DATA_WIDTH-2:0], sdi[1]};
      end
    endcase
    return res;
  endfunction

  assign rx_out.data  = data_r;
  assign rx_out.valid = valid_r;
  assign rx_out.last  = last_r;
  assign done_o       = done_r;

  // Beat count and per-word beat limit derived from the latched lane mode (mode 3 behaves as single).
  always_comb begin
    beats_s   = len_q_r;
    wb_last_s = WB_LAST_1;
    case (mode_q_r)
      2'd1: begin
        beats_s   = {1'b0, len_q_r[CNT_WIDTH-1:1]};
        wb_last_s = WB_LAST_2;
      end
      2'd2: begin
        beats_s   = {2'b00, len_q_r[CNT_WIDTH-1:2]};
        wb_last_s = WB_LAST_4;
      end
      default: begin
        beats_s   = len_q_r;
        wb_last_s = WB_LAST_1;
      end
    endcase
  end

  assign beat_s      = (state_r == S_RECV) && rx_edge_i;
  assign final_s     = (beat_cnt_r == (beats_s - CNT_ONE));
  assign boundary_s  = beat_s && ((wbeat_r == wb_last_s) || final_s);
  assign free_s      = !valid_r || rx_out.ready;
  assign shift_nxt_s = shift_in(shift_r, mode_q_r, sdi_i, lsb_first_s);

  // State register; clr_i aborts to IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else if (clr_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, clock enable and output-register load; a blocked boundary drops clk_en_o in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    clk_en_o    = 1'b0;
    load_s      = 1'b0;
    load_word_s = shift_nxt_s;
    load_last_s = final_s;
    case (state_r)
      S_IDLE: begin
        if (en_i && (beats_s != CNT_ZERO)) state_nxt_s = S_RECV;
        else                               state_nxt_s = S_IDLE;
      end
      S_RECV: begin
        clk_en_o = 1'b1;
        if (boundary_s) begin
          if (free_s) begin
            load_s = 1'b1;
            if (final_s) state_nxt_s = S_IDLE;
            else         state_nxt_s = S_RECV;
          end else begin
            state_nxt_s = S_STALL;
            clk_en_o    = 1'b0;
          end
        end else begin
          state_nxt_s = S_RECV;
        end
      end
      S_STALL: begin
        load_word_s = shift_r;
        load_last_s = stall_last_r;
        if (free_s) begin
          load_s = 1'b1;
          if (stall_last_r) state_nxt_s = S_IDLE;
          else              state_nxt_s = S_RECV;
        end else begin
          state_nxt_s = S_STALL;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Datapath: configuration latch, beat counters, shift register, output register and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r   <= CNT_ZERO;
      wbeat_r      <= WB_ZERO;
      shift_r      <= WORD_ZERO;
      data_r       <= WORD_ZERO;
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      done_r       <= 1'b0;
      stall_last_r <= 1'b0;
      len_q_r      <= LEN_RST;
      mode_q_r     <= 2'd0;
`ifdef SPI_RX_LSB_FIRST_EN
      lsb_first_r  <= 1'b0;
`endif
    end else if (clr_i) begin
      beat_cnt_r   <= CNT_ZERO;
      wbeat_r      <= WB_ZERO;
      shift_r      <= WORD_ZERO;
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      done_r       <= 1'b0;
      stall_last_r <= 1'b0;
    end else begin
      done_r <= ((state_r == S_IDLE) && en_i && (beats_s == CNT_ZERO)) || (beat_s && final_s);
      if ((state_r == S_IDLE) && len_upd_i) begin
        len_q_r     <= len_i;
        mode_q_r    <= mode_i;
`ifdef SPI_RX_LSB_FIRST_EN
        lsb_first_r <= lsb_first_i;
`endif
      end
      // A word that cannot be handed over stays in shift_r until STALL releases it.
      if (beat_s) begin
        beat_cnt_r   <= final_s ? CNT_ZERO : (beat_cnt_r + CNT_ONE);
        wbeat_r      <= boundary_s ? WB_ZERO : (wbeat_r + WB_ONE);
        stall_last_r <= final_s;
        shift_r      <= (boundary_s && free_s) ? WORD_ZERO : shift_nxt_s;
      end else if ((state_r == S_STALL) && free_s) begin
        shift_r <= WORD_ZERO;
      end
      if (load_s) begin
        data_r  <= load_word_s;
        valid_r <= 1'b1;
        last_r  <= load_last_s;
      end else if (rx_out.ready) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end
    end
  end

endmodule
